// File: rtl/fp_exp_pipe_if.sv
// Operand/result handshake bundle for the fp_exp_pipe exponent stage.
// The slave modport is the pipeline side and the master modport is the producer/consumer side.
interface fp_exp_pipe_if #(
    parameter int unsigned EXP_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [EXP_WIDTH-1:0] exp_a;
    logic [EXP_WIDTH-1:0] exp_b;
    logic [1:0]           mant_hi;
    logic                 round_ovf;
    logic                 out_valid;
    logic                 out_ready;
    logic [EXP_WIDTH+1:0] exp_res;
    logic [3:0]           flags;

    modport slave (
        input  in_valid, exp_a, exp_b, mant_hi, round_ovf, out_ready,
        output in_ready, out_valid, exp_res, flags
    );

    modport master (
        output in_valid, exp_a, exp_b, mant_hi, round_ovf, out_ready,
        input  in_ready, out_valid, exp_res, flags
    );
endinterface

// File: rtl/fp_exp_pipe.sv
// Two-stage product-exponent pipeline: biased sum with mantissa correction, then de-bias and classify.
// Define FP_EXP_SAT_EN to clamp overflow/underflow results; flags report either way.
module fp_exp_pipe #(
    parameter int unsigned IS_DOUBLE = 0,
    parameter int unsigned EXP_WIDTH = (IS_DOUBLE != 0) ? 11 : 8,
    parameter int unsigned BIAS      = (IS_DOUBLE != 0) ? 1023 : 127
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_exp_pipe_if.slave  bus
);
    localparam int unsigned RW = EXP_WIDTH + 2;
    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
    localparam logic [RW-1:0] RES_MAX = RW'((2 ** EXP_WIDTH) - 1);
    localparam logic [RW-1:0] BIAS_W  = RW'(BIAS);

    typedef struct packed {
        logic [RW-1:0] sum;
        logic          is_zero;
        logic          is_special;
    } s1_t;

    logic          s1_valid_q, s1_valid_d;
    s1_t           s1_q, s1_d;
    logic          s2_valid_q, s2_valid_d;
    logic [RW-1:0] exp_res_q, exp_res_d;
    logic [3:0]    flags_q, flags_d;

    logic          s1_adv_c;
    logic          in_ready_c;
    logic [1:0]    corr_c;
    logic [RW-1:0] raw_c;
    logic          ovf_c;
    logic          unf_c;

    assign s1_adv_c   = !s2_valid_q || bus.out_ready;
    assign in_ready_c = !s1_valid_q || s1_adv_c;

    // Normalisation/rounding correction added to the exponent sum
    always_comb begin
        corr_c = 2'd0;
        case (bus.mant_hi)
            2'b00:   corr_c = 2'd0;
            2'b01:   corr_c = {1'b0, bus.round_ovf};
            2'b10:   corr_c = 2'd1;
            default: corr_c = bus.round_ovf ? 2'd2 : 2'd1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_ready_c) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.sum        = RW'(bus.exp_a) + RW'(bus.exp_b) + RW'(corr_c);
                s1_d.is_zero    = (bus.exp_a == '0) || (bus.exp_b == '0);
                s1_d.is_special = (bus.exp_a == EXP_ONES) || (bus.exp_b == EXP_ONES);
            end
        end
    end

    // Raw result is signed; the sum is wide enough that the subtraction never wraps
    assign raw_c = s1_q.sum - BIAS_W;
    assign ovf_c = !raw_c[RW-1] && (raw_c >= RES_MAX);
    assign unf_c = raw_c[RW-1] || (raw_c == '0);

    always_comb begin
        s2_valid_d = s2_valid_q;
        exp_res_d  = exp_res_q;
        flags_d    = flags_q;
        if (s1_adv_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_q.is_special) begin
                    exp_res_d = {2'b00, EXP_ONES};
                    flags_d   = 4'b1000;
                end else if (s1_q.is_zero) begin
                    exp_res_d = '0;
                    flags_d   = 4'b0100;
                end else begin
                    exp_res_d = raw_c;
                    flags_d   = {2'b00, ovf_c, unf_c};
`ifdef FP_EXP_SAT_EN
                    if (ovf_c) begin
                        exp_res_d = RES_MAX;
                    end else if (unf_c) begin
                        exp_res_d = '0;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            exp_res_q  <= '0;
            flags_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            exp_res_q  <= exp_res_d;
            flags_q    <= flags_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = s2_valid_q;
    assign bus.exp_res   = exp_res_q;
    assign bus.flags     = flags_q;
endmodule

// File: doc/fp_exp_pipe.md
FP_EXP_PIPE -- requirements
Module: fp_exp_pipe

Interface
REQ-001 Parameter IS_DOUBLE, default 0: 0 selects single precision, 1 selects double precision.
REQ-002 Parameter EXP_WIDTH, default IS_DOUBLE ? 11 : 8: width of each biased input exponent.
REQ-003 Parameter BIAS, default IS_DOUBLE ? 1023 : 127: exponent bias subtracted from the sum.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 in_valid  input  1  input operand set valid.
REQ-007 in_ready  output  1  block accepts an operand set this cycle.
REQ-008 exp_a, exp_b  input  EXP_WIDTH  biased operand exponents.
REQ-009 mant_hi  input  2  top two bits of the product mantissa.
REQ-010 round_ovf  input  1  rounding carried into the mantissa top.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 exp_res  output  EXP_WIDTH+2  signed (two's complement) corrected, biased result exponent.
REQ-014 flags  output  4  {is_special, is_zero, ovf, unf}.

Function
REQ-015 Correction SHALL be:
- mant_hi=00 -> 0.
- mant_hi=01 -> round_ovf.
- mant_hi=10 -> 1.
- mant_hi=11 -> (round_ovf ? 2 : 1).
REQ-016 Stage 1 SHALL register sum = exp_a + exp_b + correction at EXP_WIDTH+2 bits, plus zero/special classification; no truncation is permitted.
REQ-017 Stage 2 SHALL register exp_res = sum - BIAS and the flags; latency from accepted input to out_valid is exactly 2 cycles when out_ready is held high.
REQ-018 is_zero SHALL be set when exp_a==0 or exp_b==0; exp_res is then 0.
REQ-019 is_special SHALL be set when exp_a or exp_b is all-ones; exp_res is then all-ones in the low EXP_WIDTH bits and 0 in the upper bits.
REQ-020 is_special SHALL take priority over is_zero.
REQ-021 For non-zero, non-special inputs, ovf SHALL be set when exp_res >= 2^EXP_WIDTH-1, and unf SHALL be set when exp_res <= 0.
REQ-022 Handshake rules:
- A transfer occurs when valid and ready are both high on an edge.
- in_ready = !s1_valid || s1 advances.
- s1 advances when !s2_valid || out_ready.
REQ-023 out_valid and exp_res/flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 With both stages full and out_ready=0, in_ready SHALL be 0 and no data is lost or duplicated.
REQ-025 Simultaneous input accept and output drain SHALL sustain one result per cycle at full throughput.
REQ-026 out_ready toggling SHALL never reorder results; ordering is strictly FIFO.

Reset
REQ-027 While rst_n=0 (asynchronous assertion):
- Stage valids, out_valid, exp_res and flags SHALL be 0.
- in_ready SHALL be 1 once no stage is valid.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight results; the first result after rst_n rises comes from the first post-reset accepted input.

Configuration
REQ-029 With macro FP_EXP_SAT_EN defined:
- ovf results saturate exp_res to 2^EXP_WIDTH-1.
- unf results force exp_res to 0.
- ovf/unf flags still report.
REQ-030 Without FP_EXP_SAT_EN, exp_res SHALL carry the raw signed value; the flags are unchanged.

Verification
REQ-031 Single, exp_a=127, exp_b=127, mant_hi=01, round_ovf=0, out_ready=1 -> exp_res=127, flags=0000, out_valid exactly 2 cycles after accept.
REQ-032 Single, exp_a=200, exp_b=200, mant_hi=11, round_ovf=1 -> raw 275 with ovf=1; with FP_EXP_SAT_EN, exp_res=255.
REQ-033 Single, exp_a=1, exp_b=1, mant_hi=00 -> exp_res=-125 raw, unf=1; with FP_EXP_SAT_EN, exp_res=0.
REQ-034 exp_a=0, exp_b=255 -> is_special=1, is_zero=0, exp_res=255.
REQ-035 Double, 8 back-to-back inputs with out_ready held 0 for 5 cycles -> in_ready=0 after 2 accepts, then all 8 results delivered in order with no gaps once out_ready=1; e.g. 1023+1023+corr1 -> 1024.
REQ-036 rst_n pulsed low while both stages are valid -> out_valid=0 immediately, and no stale result appears after release.
